// File: rtl/types_pkg.sv
// types_pkg: shared types for the fetch stage
package types_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_data;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: circular buffer of fetched {pc, instr} entries, flush overrides push/pop
module fetch_fifo
  import types_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  fetch_data              din,
  output fetch_data              head,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int W = AW + 1;
  fetch_data mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [W-1:0] count_q;
  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk)
    if (flush) begin
      rd_q <= '0;
      wr_q <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop) rd_q <= rd_q + 1'b1;
      count_q <= count_q + W'(push) - W'(pop);
    end
  // storage needs no reset; only entries below count are ever read
  always_ff @(posedge clk)
    if (push && !flush) mem_q[wr_q] <= din;
  assign head = mem_q[rd_q];
  assign count = count_q;
endmodule

// File: rtl/fetch.sv
// fetch: sequential instruction fetch with buffered delivery and redirect flush
module fetch
  import types_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instr,
  output logic [31:0] pc_out,
  output logic        valid_out,
  input  logic        ready_out
);
  localparam int CW = $clog2(DEPTH) + 2;
  logic [31:0] pc_q, pc_d, ipc_q;
  logic inflight_q, kill_q, deq;
  logic [$clog2(DEPTH):0] count;
  logic [CW-1:0] occ;
  fetch_data head;
  assign deq = valid_out && ready_out;
  assign occ = CW'(count) + CW'(inflight_q) - CW'(deq);
  assign imem_en = !reset && !redirect_valid && (occ < CW'(DEPTH));
  assign imem_addr = pc_q;
  // redirect wins over sequential advance
  always_comb begin
    pc_d = redirect_valid ? (redirect_pc & ~32'd3) : imem_en ? pc_q + 32'd4 : pc_q;
  end
  // pc, in-flight tracking and kill of a response issued before a redirect
  always_ff @(posedge clk)
    if (reset) begin
      pc_q <= RESET_PC;
      inflight_q <= 1'b0;
      kill_q <= 1'b0;
      ipc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
      inflight_q <= imem_en;
      kill_q <= redirect_valid && inflight_q;
      ipc_q <= pc_q;
    end
  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .push(inflight_q && !kill_q),
    .pop(deq),
    .flush(reset || redirect_valid),
    .din('{pc: ipc_q, instr: imem_rdata}),
    .head(head),
    .count(count)
  );
  assign valid_out = (count != '0);
  assign instr = head.instr;
  assign pc_out = head.pc;
endmodule

// File: tb/tb_fetch.sv
// tb_fetch: stream-level reference model check of fetch with directed and random steps
module tb_fetch;
  localparam logic [31:0] RPC = 32'h100;
  localparam int DEPTH = 2;
  localparam logic [31:0] K = 32'hA5A5_0000;
  logic clk = 0, reset = 1, imem_en, redirect_valid = 0, valid_out, ready_out = 1;
  logic [31:0] imem_addr, imem_rdata, redirect_pc = 0, instr, pc_out;
  int n_vec = 0, n_err = 0, ndeq = 0, ne;
  logic [31:0] exp_pc = RPC, iss_pc = RPC, hold_pc, hold_in;
  bit hold_v = 0, after_flush = 0;

  fetch #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .imem_en(imem_en), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr(instr), .pc_out(pc_out), .valid_out(valid_out), .ready_out(ready_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) imem_rdata <= imem_en ? (imem_addr ^ K) : 32'hDEAD_BEEF;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // one cycle: drive inputs, check against the instruction-stream model, update model
  task automatic cyc(input bit r, input bit rd, input logic [31:0] rp, input bit rdy);
    @(negedge clk);
    reset = r; redirect_valid = rd; redirect_pc = rp; ready_out = rdy;
    #1;
    if (r) chk("rst_en", 32'(imem_en), 0);
    else begin
      if (hold_v) begin
        chk("hold_v", 32'(valid_out), 1);
        chk("hold_pc", pc_out, hold_pc);
        chk("hold_instr", instr, hold_in);
      end
      if (after_flush) chk("flush_v", 32'(valid_out), 0);
      if (valid_out === 1'b1 && rdy) begin
        chk("deq_pc", pc_out, exp_pc);
        chk("deq_instr", instr, exp_pc ^ K);
        exp_pc += 4;
        ndeq++;
      end
      chk("en_rule", 32'(imem_en), 32'(!rd && (((iss_pc - exp_pc) >> 2) < DEPTH)));
      if (imem_en === 1'b1) begin
        chk("addr", imem_addr, iss_pc);
        iss_pc += 4;
      end
    end
    hold_v = !r && !rd && valid_out === 1'b1 && !rdy;
    hold_pc = pc_out;
    hold_in = instr;
    after_flush = r || rd;
    if (r) begin exp_pc = RPC; iss_pc = RPC; end
    else if (rd) begin exp_pc = rp & ~32'd3; iss_pc = rp & ~32'd3; end
  endtask

  initial begin
    repeat (3) cyc(1, 0, 0, 1);
    cyc(0, 0, 0, 1);
    chk("first_en", 32'(imem_en), 1);
    chk("first_addr", imem_addr, 32'h100);
    chk("first_v", 32'(valid_out), 0);
    cyc(0, 0, 0, 1);
    chk("addr1", imem_addr, 32'h104);
    chk("v1", 32'(valid_out), 0);
    cyc(0, 0, 0, 1);
    chk("addr2", imem_addr, 32'h108);
    chk("v2", 32'(valid_out), 1);
    chk("pc2", pc_out, 32'h100);
    chk("instr2", instr, 32'hA5A5_0100);
    repeat (8) begin
      cyc(0, 0, 0, 1);
      chk("thru_v", 32'(valid_out), 1);
    end
    ne = 0;
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0, 0);
      if (imem_en === 1'b1) ne++;
    end
    chk("stall_en_off", 32'(imem_en), 0);
    chk("stall_issues", 32'(ne <= 2), 1);
    cyc(0, 0, 0, 1);
    chk("resume_en", 32'(imem_en), 1);
    cyc(0, 1, 32'h0000_2002, 0);
    chk("redir_en", 32'(imem_en), 0);
    cyc(0, 0, 0, 1);
    chk("r1_v", 32'(valid_out), 0);
    chk("r1_en", 32'(imem_en), 1);
    chk("r1_addr", imem_addr, 32'h2000);
    cyc(0, 0, 0, 1);
    chk("r2_v", 32'(valid_out), 0);
    cyc(0, 0, 0, 1);
    chk("r3_v", 32'(valid_out), 1);
    chk("r3_pc", pc_out, 32'h2000);
    ne = ndeq;
    cyc(0, 1, 32'h0000_4000 | ($urandom & 32'h0000_0FFC), 1);
    chk("hs_redir_deq", 32'(ndeq - ne), 1);
    repeat (5) cyc(0, 0, 0, 1);
    cyc(0, 1, 32'hFFFF_FFF8, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    chk("wrap0", pc_out, 32'hFFFF_FFF8);
    cyc(0, 0, 0, 1);
    chk("wrap1", pc_out, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 1);
    chk("wrap2", pc_out, 32'h0000_0000);
    repeat (3) cyc(0, 0, 0, 1);
    chk("pre_rst_v", 32'(valid_out), 1);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 1);
    chk("rst1_v", 32'(valid_out), 0);
    chk("rst1_addr", imem_addr, RPC);
    cyc(0, 0, 0, 1);
    chk("rst2_v", 32'(valid_out), 0);
    cyc(0, 0, 0, 1);
    chk("rst3_pc", pc_out, RPC);
    for (int i = 0; i < 400; i++)
      cyc($urandom % 64 == 0, $urandom % 12 == 0, $urandom, $urandom % 4 != 0);
    for (int i = 0; i < 12; i++) begin
      cyc(0, 0, 0, 1);
      if (i >= 6) chk("drain_v", 32'(valid_out), 1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fetch.md
# fetch

Instruction fetch stage directly upstream of `decode`. Holds the architectural fetch PC and issues sequential word reads to a fixed 1-cycle-latency instruction memory. It buffers returned words with their PCs in a small FIFO and presents them to `decode` over a valid/ready handshake. A redirect input (branch/jump resolution, flush) steers the PC and discards all buffered and in-flight fetches.

## Interface
- `RESET_PC`, 32'h0000_0000: PC fetched first after reset.
- `DEPTH`, 2: instruction buffer entries; ≥2, power of two.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `imem_en`  out  1  read request this cycle.
- `imem_addr`  out  32  word-aligned read address, valid when `imem_en`.
- `imem_rdata`  in  32  instruction word, valid exactly one cycle after the `imem_en` cycle.
- `redirect_valid`  in  1  flush and restart fetch.
- `redirect_pc`  in  32  new fetch PC; bits [1:0] are ignored and treated as 0.
- `instr`  out  32  instruction to decode (head of buffer).
- `pc_out`  out  32  PC of `instr`; drives decode `pc_in`.
- `valid_out`  out  1  `instr`/`pc_out` valid.
- `ready_out`  in  1  decode can accept (decode `ready_in`).

## Operation
- State: `pc` (next fetch address), `inflight` (1 bit, request issued last cycle), `kill` (1 bit, drop next response), and a FIFO of `{pc, instr}` with `count`.
- Dequeue: `deq = valid_out && ready_out`; pops the head at the edge.
- Issue rule: `imem_en = !reset && !redirect_valid && (count + inflight - deq < DEPTH)`. On issue, `imem_addr = pc` and `pc <= pc + 4`, with natural 32-bit wrap (32'hFFFF_FFFC → 0).
- Response: in the cycle after an issue, `imem_rdata` is pushed with the issuing PC (registered alongside `inflight`), unless `kill` is set. The issue rule guarantees the push never overflows.
- Simultaneous push and pop in the same cycle: `count` is unchanged, order is preserved, and an empty-FIFO push is not bypassed to the output.
- Redirect has highest priority:
  - `pc <= {redirect_pc[31:2],2'b00}`; FIFO cleared (`count <= 0`).
  - `kill <= inflight`, so the response arriving next cycle is dropped.
  - No issue in the redirect cycle.
  - A handshake (`deq`) in the same cycle still completes: that instruction counts as delivered.
- Redirect on consecutive cycles: the last one wins. Each redirect cycle suppresses issue.
- `valid_out = (count != 0)`. `instr`/`pc_out` come from the head and are don't-care when `valid_out` is 0.
- While `valid_out && !ready_out`, `instr`/`pc_out` are held stable.

## Timing
- Reset values:
  - `pc = RESET_PC`, `count = 0`, `inflight = 0`, `kill = 0`.
  - `valid_out = 0`, `imem_en = 0`. Address and data outputs are don't-care while `valid_out`/`imem_en` are 0.
- Reset asserted mid-operation: same state as above at the next edge. The in-flight response is ignored because `inflight` is cleared.
- Latency: issue in cycle N → data returns in N+1 → push at end of N+1 → `valid_out` in N+2.
- First cycle after reset deasserts: `imem_en = 1`, `imem_addr = RESET_PC`.
- Throughput: with `DEPTH = 2` and `ready_out` held high, one instruction per cycle in steady state.
- Redirect in cycle R:
  - `valid_out` is 0 in R+1.
  - First request to the new PC is issued in R+1.
  - Its instruction is visible in R+3.
- Backpressure: with `ready_out = 0`, the FIFO fills to `DEPTH` and `imem_en` drops. Fetch resumes in the same cycle `ready_out` returns high, because `deq` is counted in the issue rule.

## Structure
- Add `fetch_data` (`pc`, `instr`, both 32-bit) to `types_pkg`; the FIFO stores this type.
- One sub-module, `fetch_fifo`: parameterised circular buffer with `push`, `pop`, `flush`, `count`, `head`.
  - Pointers wrap modulo `DEPTH`.
  - `flush` overrides both push and pop.
- PC, issue and kill logic live in `fetch`.

## Test plan
- Reset release, `RESET_PC = 32'h100`, `ready_out = 1`, imem returns `addr ^ 32'hA5A5_0000`:
  - `imem_addr` = 0x100, 0x104, 0x108 on consecutive cycles.
  - `valid_out` first high 2 cycles after the first issue, with `pc_out = 0x100`, `instr = 0xA5A5_0100`.
  - Thereafter one instruction per cycle.
- Backpressure: drop `ready_out` for 5 cycles.
  - At most 2 issues after the stall; `imem_en` then stays 0.
  - `pc_out`/`instr` held stable.
  - On release, PCs continue with no gap or duplicate.
- Redirect to 32'h0000_2002 while one request is in flight and the FIFO is full:
  - Next cycle `valid_out = 0`; the old response is dropped.
  - Next `imem_addr = 0x2000`.
  - First delivered `pc_out = 0x2000`.
- Redirect in the same cycle as a handshake: the handshaken instruction is delivered once, and no older PC appears afterward.
- Wrap-around: redirect to 32'hFFFF_FFF8. Delivered PCs are FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Reset asserted mid-stream with the FIFO non-empty:
  - Next cycle `valid_out = 0`.
  - The stale imem response is ignored.
  - Fetch restarts at `RESET_PC`.
